// File: rtl/debug_cmd_pkg.sv
// Shared constants, state encoding and small helpers for the debug command controller.
// Opcode and reply byte values match the host-side debug tool.
package debug_cmd_pkg;

    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] OP_ECHO   = 8'h45;
    localparam logic [7:0] OP_STATUS = 8'h53;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    localparam logic [7:0] ERR_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG,
        ST_EXEC,
        ST_TX_REQ,
        ST_TX_WAIT
    } state_e;

    function automatic logic needs_arg(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_ECHO);
    endfunction

    function automatic logic is_known_op(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE) || (op == OP_ECHO) || (op == OP_STATUS);
    endfunction

    // Error counter sticks at ERR_MAX so a flood of errors stays visible.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/probe_sync.sv
// Two-flop synchroniser for the asynchronous probe pins.
// Both stages clear on reset so 'R' reads zero until real samples arrive.
module probe_sync #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/debug_cmd_ctrl.sv
// Byte-command controller between UART receiver and transmitter: parses opcode/argument,
// executes, and sends one reply byte. Define DEBUG_CMD_TIMEOUT_EN to build the ARG timeout.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for an opcode byte
// ST_ARG     | opcode latched, waiting for its argument byte
// ST_EXEC    | one cycle: compute reply, apply LED write
// ST_TX_REQ  | reply ready, waiting for transmitter to be free
// ST_TX_WAIT | tx_start issued, waiting for transmitter to finish
module debug_cmd_ctrl
    import debug_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1200000,
    parameter int LED_W          = 4
) (
    input  logic             iCE_CLK,
    input  logic             rst_n,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    input  logic [7:0]       probe_in,
    input  logic             tx_busy,
    output logic [7:0]       tx_byte,
    output logic             tx_start,
    output logic [LED_W-1:0] led,
    output logic             cmd_err,
    output logic             busy
);

    state_e           state_q;
    logic [7:0]       opcode_q;
    logic [7:0]       arg_q;
    logic [7:0]       tx_byte_q;
    logic             tx_start_q;
    logic [LED_W-1:0] led_q;
    logic             cmd_err_q;
    logic [7:0]       err_count_q;
    logic [7:0]       err_count_d;

    logic [7:0]       probe_s;
    logic             overrun;
    logic             nak;
    logic             timeout;
    logic             err_event;

    probe_sync #(.W(8)) u_probe_sync (
        .clk_i   (iCE_CLK),
        .rst_n_i (rst_n),
        .d_i     (probe_in),
        .q_o     (probe_s)
    );

    assign overrun = rx_valid && ((state_q == ST_EXEC) || (state_q == ST_TX_REQ) ||
                                  (state_q == ST_TX_WAIT));
    assign nak     = (state_q == ST_EXEC) && !is_known_op(opcode_q);

`ifdef DEBUG_CMD_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] timer_q;

    // Reloaded on every entry to ARG; terminal count ends the wait.
    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if ((state_q == ST_IDLE) && rx_valid && needs_arg(rx_byte)) begin
            timer_q <= TMR_LOAD;
        end else if ((state_q == ST_ARG) && (timer_q != '0)) begin
            timer_q <= timer_q - TMR_W'(1);
        end
    end

    assign timeout = (state_q == ST_ARG) && !rx_valid && (timer_q == '0);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    // Coincident error sources collapse into a single count and a single pulse.
    assign err_event   = overrun || nak || timeout;
    assign err_count_d = err_event ? sat_inc(err_count_q) : err_count_q;

    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            arg_q       <= '0;
            tx_byte_q   <= '0;
            tx_start_q  <= 1'b0;
            led_q       <= '0;
            cmd_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            tx_start_q  <= 1'b0;
            cmd_err_q   <= err_event;
            err_count_q <= err_count_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        opcode_q <= rx_byte;
                        state_q  <= needs_arg(rx_byte) ? ST_ARG : ST_EXEC;
                    end
                end
                ST_ARG: begin
                    if (rx_valid) begin
                        arg_q   <= rx_byte;
                        state_q <= ST_EXEC;
                    end else if (timeout) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    case (opcode_q)
                        OP_READ:   tx_byte_q <= probe_s;
                        OP_WRITE: begin
                            led_q     <= arg_q[LED_W-1:0];
                            tx_byte_q <= ACK;
                        end
                        OP_ECHO:   tx_byte_q <= arg_q;
                        OP_STATUS: tx_byte_q <= err_count_q;
                        default:   tx_byte_q <= NAK;
                    endcase
                    state_q <= ST_TX_REQ;
                end
                ST_TX_REQ: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        state_q    <= ST_TX_WAIT;
                    end
                end
                ST_TX_WAIT: begin
                    // tx_start_q is high only in the first TX_WAIT cycle, before busy can rise.
                    if (!tx_start_q && !tx_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_byte  = tx_byte_q;
    assign tx_start = tx_start_q;
    assign led      = led_q;
    assign cmd_err  = cmd_err_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Scoreboard bench for debug_cmd_ctrl: stimulus pushes expected replies from a reference
// model, a monitor pops them on every tx_start and also emulates the transmitter's busy.
`timescale 1ns/1ps
module tb_debug_cmd_ctrl;

    localparam int LED_W = 4;
    localparam int TMO   = 50;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic [7:0]       rx_byte  = 8'h00;
    logic             rx_valid = 1'b0;
    logic [7:0]       probe_in = 8'h00;
    logic             tx_busy  = 1'b0;
    logic [7:0]       tx_byte;
    logic             tx_start;
    logic [LED_W-1:0] led;
    logic             cmd_err;
    logic             busy;

    debug_cmd_ctrl #(.TIMEOUT_CYCLES(TMO), .LED_W(LED_W)) dut (
        .iCE_CLK  (clk),
        .rst_n    (rst_n),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .probe_in (probe_in),
        .tx_busy  (tx_busy),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .led      (led),
        .cmd_err  (cmd_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_cmp       = 0;
    int n_bad       = 0;
    int cyc         = 0;
    int cmd_rx_cyc  = 0;
    int err_pulses  = 0;
    int starts      = 0;
    int busy_left   = 0;
    bit force_busy  = 1'b0;
    bit prev_start  = 1'b0;

    // Reference model state
    logic [7:0]       m_err    = 8'h00;
    logic [LED_W-1:0] m_led    = '0;
    int               m_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor + transmitter emulation
    always @(negedge clk) begin
        if (cmd_err) err_pulses++;
        if (tx_start) begin
            starts++;
            n_cmp++;
            if (prev_start) begin
                n_bad++;
                $display("FAIL tx_start_width: tx_start high %0d cycles in a row, required 1", 2);
            end
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_tx_start: tx_byte=%02h, required no transmission", tx_byte);
            end else begin
                mon_e = sb.pop_front();
                if (tx_byte !== mon_e.data) begin
                    n_bad++;
                    $display("FAIL reply_byte: got %02h required %02h", tx_byte, mon_e.data);
                end
                if (mon_e.lat >= 0) begin
                    n_cmp++;
                    if (cyc - cmd_rx_cyc != mon_e.lat) begin
                        n_bad++;
                        $display("FAIL reply_latency: got %0d cycles required %0d",
                                 cyc - cmd_rx_cyc, mon_e.lat);
                    end
                end
            end
            busy_left = $urandom_range(1, 6);
        end else if (busy_left > 0) begin
            busy_left--;
        end
        prev_start = tx_start;
        tx_busy    = force_busy || (busy_left > 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic void bump_err();
        m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
        m_pulses++;
    endfunction

    function automatic logic [7:0] model_cmd(input logic [7:0] op, input logic [7:0] arg);
        case (op)
            8'h52: return probe_in;
            8'h57: begin
                m_led = arg[LED_W-1:0];
                return 8'h06;
            end
            8'h45: return arg;
            8'h53: return m_err;
            default: begin
                bump_err();
                return 8'h15;
            end
        endcase
    endfunction

    function automatic bit has_arg(input logic [7:0] op);
        return (op == 8'h57) || (op == 8'h45);
    endfunction

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        cmd_rx_cyc = cyc;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 600) begin
            n_bad++;
            $display("FAIL %s_idle_timeout: busy=%0d pending=%0d after %0d cycles, required idle",
                     name, busy, sb.size(), n);
        end
        @(negedge clk);
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [7:0] arg, input bit ovr,
                          input bit chk_lat);
        exp_t e;
        int   n;
        e.data = model_cmd(op, arg);
        e.lat  = chk_lat ? 2 : -1;
        sb.push_back(e);
        send(op);
        if (has_arg(op)) send(arg);
        if (ovr) begin
            n = 0;
            while (!tx_start && n < 50) begin
                @(negedge clk);
                n++;
            end
            n_cmp++;
            if (n >= 50) begin
                n_bad++;
                $display("FAIL overrun_wait: no tx_start within %0d cycles", n);
            end
            send(8'hAA);
            bump_err();
        end
        wait_idle("cmd");
    endtask

    task automatic check_state(input string name);
        check({name, "_led"}, led, m_led);
        check({name, "_err_pulses"}, err_pulses, m_pulses);
    endtask

    initial begin
        logic [7:0] op;
        logic [7:0] arg;
        exp_t       e;
        int         s0;

        repeat (2) @(negedge clk);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_led", led, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        probe_in = 8'hA5;
        repeat (4) @(negedge clk);

        do_cmd(8'h52, 8'h00, 1'b0, 1'b1);
        check_state("read_probe");

        force_busy = 1'b1;
        @(negedge clk);
        s0 = starts;
        e.data = model_cmd(8'h57, 8'h0C);
        e.lat  = -1;
        sb.push_back(e);
        send(8'h57);
        send(8'h0C);
        repeat (100) @(negedge clk);
        check("held_no_tx_start", starts - s0, 0);
        check("held_busy", busy, 1);
        check("held_led", led, 4'hC);
        force_busy = 1'b0;
        wait_idle("held");
        check("held_one_start", starts - s0, 1);

        do_cmd(8'h45, 8'h3C, 1'b0, 1'b1);
        do_cmd(8'h53, 8'h00, 1'b0, 1'b1);
        check_state("echo_status");

        do_cmd(8'h99, 8'h00, 1'b0, 1'b1);
        check_state("nak");
        do_cmd(8'h53, 8'h00, 1'b0, 1'b1);

        do_cmd(8'h45, 8'h77, 1'b1, 1'b1);
        check_state("overrun_tx_wait");

        // NAK in EXEC coinciding with an overrun byte
        e.data = model_cmd(8'hC3, 8'h00);
        e.lat  = -1;
        sb.push_back(e);
        send(8'hC3);
        send(8'h11);
        wait_idle("nak_overrun");
        check_state("nak_overrun");
        do_cmd(8'h53, 8'h00, 1'b0, 1'b1);

`ifdef DEBUG_CMD_TIMEOUT_EN
        send(8'h57);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_still_waiting", busy, 1);
        @(negedge clk);
        check("tmo_back_idle", busy, 0);
        bump_err();
        repeat (3) @(negedge clk);
        check_state("timeout");
        do_cmd(8'h53, 8'h00, 1'b0, 1'b1);
`else
        send(8'h57);
        repeat (3 * TMO) @(negedge clk);
        check("no_tmo_still_waiting", busy, 1);
        e.data = model_cmd(8'h57, 8'h09);
        e.lat  = 2;
        sb.push_back(e);
        send(8'h09);
        wait_idle("no_tmo");
        check_state("no_timeout");
`endif

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: op = 8'h52;
                1: op = 8'h57;
                2: op = 8'h45;
                3: op = 8'h53;
                default: op = 8'($urandom_range(0, 255));
            endcase
            arg = 8'($urandom_range(0, 255));
            probe_in = 8'($urandom_range(0, 255));
            repeat (3) @(negedge clk);
            do_cmd(op, arg, ($urandom_range(0, 4) == 0), 1'b1);
        end
        check_state("random");

        for (int i = 0; i < 300; i++) do_cmd(8'hF0, 8'h00, 1'b0, 1'b0);
        do_cmd(8'h53, 8'h00, 1'b0, 1'b1);
        check("err_saturated", m_err, 8'hFF);
        check_state("saturate");

        do_cmd(8'h57, 8'h05, 1'b0, 1'b1);
        send(8'h57);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_byte", tx_byte, 0);
        check("midrst_tx_start", tx_start, 0);
        check("midrst_led", led, 0);
        check("midrst_cmd_err", cmd_err, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_led = '0;
        m_err = 8'h00;
        @(negedge clk);
        do_cmd(8'h53, 8'h00, 1'b0, 1'b1);
        do_cmd(8'h45, 8'h5A, 1'b0, 1'b1);
        check_state("after_reset");
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
